// File: rtl/aoc_types_pkg.sv
// rtl/aoc_types_pkg.sv - shared connection types and top-K drain states
package aoc_types_pkg;

  localparam int CONN_PT_W   = 10;
  localparam int CONN_DIST_W = 32;

  typedef struct packed {
    logic [CONN_DIST_W-1:0] distance;
    logic [CONN_PT_W-1:0]   pointa;
    logic [CONN_PT_W-1:0]   pointb;
  } conn_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } topk_state_e;

endpackage

// File: rtl/topk_slot.sv
// rtl/topk_slot.sv - one entry of the sorted insertion array
// Inserts shift entries toward the tail, drains shift them toward the head.
module topk_slot
  import aoc_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ins,
  input  logic  shift,
  input  conn_t conn_in,
  input  logic  prev_lt,
  input  logic  prev_vld,
  input  conn_t prev_conn,
  input  logic  next_vld,
  input  conn_t next_conn,
  output logic  vld,
  output conn_t conn,
  output logic  lt
);

  // Strict compare keeps an equal-distance earlier arrival ahead of the newcomer.
  assign lt = !vld || (conn_in.distance < conn.distance);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      conn <= '0;
    end else if (ins) begin
      if (prev_lt) begin
        vld  <= prev_vld;
        conn <= prev_conn;
      end else if (lt) begin
        vld  <= 1'b1;
        conn <= conn_in;
      end
    end else if (shift) begin
      vld  <= next_vld;
      conn <= next_conn;
    end
  end

endmodule

// File: rtl/conn_topk.sv
// rtl/conn_topk.sv - keeps the K shortest connections and drains them shortest-first
// FILL inserts one connection per cycle; DRAIN streams slot 0 out; DONE holds.
module conn_topk
  import aoc_types_pkg::*;
#(
  parameter int K         = 1000,
  parameter int NUM_CONNS = 499500
) (
  input  logic  clk,
  input  logic  rst,
  input  conn_t conn_in,
  input  logic  conn_in_vld,
  output conn_t conn_out,
  output logic  conn_out_vld,
  input  logic  conn_out_rdy,
  output logic  conn_out_last,
  output logic  done,
  output logic  ovf_err
);

  localparam int CNT_W = $clog2(NUM_CONNS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CONNS - 1);
  localparam int NXT = (K > 1) ? 1 : 0;

  topk_state_e      state, state_nxt;
  logic [CNT_W-1:0] in_cnt;
  logic [K-1:0]     slot_vld;
  logic [K-1:0]     lt;
  conn_t            slot_conn [K];
  logic             ins;
  logic             hs;
  logic             lt_unused;

  assign ins       = (state == FILL) && conn_in_vld;
  assign hs        = conn_out_vld && conn_out_rdy;
  // The tail compare only decides whether the input is dropped; nothing downstream needs it.
  assign lt_unused = lt[K-1];

  for (genvar i = 0; i < K; i++) begin : g_slot
    logic  prev_lt, prev_vld, next_vld;
    conn_t prev_conn, next_conn;

    if (i == 0) begin : g_head
      assign prev_lt   = 1'b0;
      assign prev_vld  = 1'b0;
      assign prev_conn = '0;
    end else begin : g_body
      assign prev_lt   = lt[i-1];
      assign prev_vld  = slot_vld[i-1];
      assign prev_conn = slot_conn[i-1];
    end

    if (i == K - 1) begin : g_tail
      assign next_vld  = 1'b0;
      assign next_conn = '0;
    end else begin : g_inner
      assign next_vld  = slot_vld[i+1];
      assign next_conn = slot_conn[i+1];
    end

    topk_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .ins       (ins),
      .shift     (hs),
      .conn_in   (conn_in),
      .prev_lt   (prev_lt),
      .prev_vld  (prev_vld),
      .prev_conn (prev_conn),
      .next_vld  (next_vld),
      .next_conn (next_conn),
      .vld       (slot_vld[i]),
      .conn      (slot_conn[i]),
      .lt        (lt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      in_cnt  <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ins)
        in_cnt <= in_cnt + 1'b1;
      if (conn_in_vld && (state != FILL))
        ovf_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    conn_out      = '0;
    conn_out_vld  = 1'b0;
    conn_out_last = 1'b0;
    done          = 1'b0;
    case (state)
      FILL: begin
        if (ins && (in_cnt == LAST_CNT))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        conn_out      = slot_conn[0];
        conn_out_vld  = slot_vld[0];
        conn_out_last = slot_vld[0] && ((K == 1) || !slot_vld[NXT]);
        // Taking the final entry goes straight to DONE so done follows the last beat.
        if (!slot_vld[0] || (hs && conn_out_last))
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: tb/tb_conn_topk.sv
// tb/tb_conn_topk.sv - scoreboard bench for conn_topk (K=4, NUM_CONNS=6 and NUM_CONNS=2)
module tb_conn_topk;
  import aoc_types_pkg::*;

  typedef struct packed {
    conn_t c;
    logic  last;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  conn_t in6, in2, out6, out2;
  logic  iv6, iv2, ov6, ov2, rdy6, rdy2, last6, last2, done6, done2, ovf6, ovf2;
  logic  dn6_pend, dn2_pend;
  conn_t held;
  exp_t  q6[$];
  exp_t  q2[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  conn_topk #(.K(4), .NUM_CONNS(6)) dut6 (
    .clk(clk), .rst(rst), .conn_in(in6), .conn_in_vld(iv6), .conn_out(out6),
    .conn_out_vld(ov6), .conn_out_rdy(rdy6), .conn_out_last(last6), .done(done6),
    .ovf_err(ovf6)
  );

  conn_topk #(.K(4), .NUM_CONNS(2)) dut2 (
    .clk(clk), .rst(rst), .conn_in(in2), .conn_in_vld(iv2), .conn_out(out2),
    .conn_out_vld(ov2), .conn_out_rdy(rdy2), .conn_out_last(last2), .done(done2),
    .ovf_err(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic conn_t mk(input int d, input int pa, input int pb);
    conn_t r;
    r.distance = CONN_DIST_W'(d);
    r.pointa   = CONN_PT_W'(pa);
    r.pointb   = CONN_PT_W'(pb);
    return r;
  endfunction

  task automatic push(input bit which, input int d, input int pa, input int pb, input bit last);
    exp_t e;
    e.c    = mk(d, pa, pb);
    e.last = last;
    if (which) q2.push_back(e);
    else       q6.push_back(e);
  endtask

  task automatic send(input bit which, input int d, input int pa, input int pb);
    if (which) begin
      in2 = mk(d, pa, pb);
      iv2 = 1'b1;
    end else begin
      in6 = mk(d, pa, pb);
      iv6 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv6 = 1'b0;
    iv2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q6.delete();
    q2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input bit which, input string name);
    int n;
    n = 0;
    while (!(which ? done2 : done6) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, which ? done2 : done6, 1);
    chk({name, "_drained"}, which ? q2.size() : q6.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      dn6_pend = 1'b0;
    end else begin
      if (dn6_pend) begin
        chk("done6_after_last", done6, 1);
        dn6_pend = 1'b0;
      end
      if (ov6 && rdy6) begin
        if (q6.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out6_extra actual=%0d expected=none", out6.distance);
        end else begin
          e = q6.pop_front();
          chk("out6_conn", out6, e.c);
          chk("out6_last", last6, e.last);
          if (last6) dn6_pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      dn2_pend = 1'b0;
    end else begin
      if (dn2_pend) begin
        chk("done2_after_last", done2, 1);
        dn2_pend = 1'b0;
      end
      if (ov2 && rdy2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out2_extra actual=%0d expected=none", out2.distance);
        end else begin
          e = q2.pop_front();
          chk("out2_conn", out2, e.c);
          chk("out2_last", last2, e.last);
          if (last2) dn2_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv6 = 1'b0; iv2 = 1'b0; in6 = '0; in2 = '0;
    rdy6 = 1'b1; rdy2 = 1'b1; dn6_pend = 1'b0; dn2_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld6", ov6, 0);
    chk("rst_out6", out6, 0);
    chk("rst_last6", last6, 0);
    chk("rst_done6", done6, 0);
    chk("rst_ovf6", ovf6, 0);
    chk("rst_vld2", ov2, 0);

    // basic ordering
    @(posedge clk); #1;
    push(0, 10, 1, 101, 0); push(0, 20, 4, 104, 0); push(0, 30, 3, 103, 0); push(0, 40, 2, 102, 1);
    send(0, 50, 0, 100); send(0, 10, 1, 101); send(0, 40, 2, 102);
    send(0, 30, 3, 103); send(0, 20, 4, 104); send(0, 60, 5, 105);
    @(negedge clk);
    chk("t1_latency", ov6, 1);
    wait_done(0, "t1_done");
    chk("t1_vld_in_done", ov6, 0);
    chk("t1_ovf", ovf6, 0);

    // ties keep arrival order
    do_reset();
    push(0, 5, 1, 11, 0); push(0, 5, 2, 12, 0); push(0, 9, 3, 13, 0); push(0, 9, 4, 14, 1);
    send(0, 5, 1, 11); send(0, 5, 2, 12); send(0, 9, 3, 13);
    send(0, 9, 4, 14); send(0, 9, 5, 15); send(0, 9, 6, 16);
    wait_done(0, "t2_done");

    // backpressure mid-drain
    do_reset();
    rdy6 = 1'b0;
    push(0, 1, 5, 25, 0); push(0, 2, 4, 24, 0); push(0, 3, 6, 26, 0); push(0, 4, 3, 23, 1);
    send(0, 8, 1, 21); send(0, 6, 2, 22); send(0, 4, 3, 23);
    send(0, 2, 4, 24); send(0, 1, 5, 25); send(0, 3, 6, 26);
    rdy6 = 1'b1;
    @(posedge clk); #1;
    rdy6 = 1'b0;
    held = out6;
    chk("t3_held", held, mk(2, 4, 24));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stable_conn", out6, held);
      chk("t3_stable_vld", ov6, 1);
    end
    @(posedge clk); #1;
    rdy6 = 1'b1;
    wait_done(0, "t3_done");

    // fewer inputs than slots
    do_reset();
    push(1, 3, 2, 32, 0); push(1, 7, 1, 31, 1);
    send(1, 7, 1, 31); send(1, 3, 2, 32);
    @(negedge clk);
    chk("t4_latency", ov2, 1);
    wait_done(1, "t4_done");
    chk("t4_ovf", ovf2, 0);

    // input during drain
    do_reset();
    rdy6 = 1'b0;
    push(0, 10, 1, 101, 0); push(0, 20, 4, 104, 0); push(0, 30, 3, 103, 0); push(0, 40, 2, 102, 1);
    send(0, 50, 0, 100); send(0, 10, 1, 101); send(0, 40, 2, 102);
    send(0, 30, 3, 103); send(0, 20, 4, 104); send(0, 60, 5, 105);
    send(0, 1, 9, 109);
    @(negedge clk);
    chk("t5_ovf_set", ovf6, 1);
    @(posedge clk); #1;
    rdy6 = 1'b1;
    wait_done(0, "t5_done");
    chk("t5_ovf_sticky", ovf6, 1);

    // reset mid-drain then a fresh run
    do_reset();
    push(0, 10, 1, 101, 0); push(0, 20, 4, 104, 0); push(0, 30, 3, 103, 0); push(0, 40, 2, 102, 1);
    send(0, 50, 0, 100); send(0, 10, 1, 101); send(0, 40, 2, 102);
    send(0, 30, 3, 103); send(0, 20, 4, 104); send(0, 60, 5, 105);
    @(posedge clk); #1;
    rst = 1'b1;
    q6.delete();
    #1;
    chk("t6_rst_vld", ov6, 0);
    chk("t6_rst_out", out6, 0);
    chk("t6_rst_last", last6, 0);
    chk("t6_rst_done", done6, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(0, 50, 6, 56, 0); push(0, 60, 5, 55, 0); push(0, 70, 4, 54, 0); push(0, 80, 3, 53, 1);
    send(0, 100, 1, 51); send(0, 90, 2, 52); send(0, 80, 3, 53);
    send(0, 70, 4, 54); send(0, 60, 5, 55); send(0, 50, 6, 56);
    wait_done(0, "t6_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
